cpu_debug_jtag_master: RTL and testbench

Initiator side of the CPU debug-slave virtual-JTAG interface. The block accepts a command containing an IR value and a DR word. It then drives the full virtual-JTAG sequence into the debug slave's TAP-side inputs: UIR, CDR, SHIFT, UDR, then RTI. While shifting, it captures the slave's returned DR bits and presents them as a response. It replaces the hardware sld hub in system-level benches and in the on-chip self-test harness, so the debug slave's take_action paths can be exercised from a plain clk-domain command port.

---
 rtl/cpu_debug_jtag_master.sv | 116 +++++++++++
 tb/tb_cpu_debug_jtag_master.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_debug_jtag_master.sv
// Virtual-JTAG initiator: turns one clk-domain command (IR + DR word) into the
// UIR/CDR/SHIFT/UDR/RTI sequence for a debug slave and returns the shifted-out DR bits.
module cpu_debug_jtag_master #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo,
    output logic [IR_WIDTH-1:0] ir_in,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti
);
    localparam int HCW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int BCW = $clog2(DR_WIDTH + 1);

    // Handshake: a command transfers on any rising edge where cmd_valid && cmd_ready;
    // rsp_valid is a one-cycle pulse with no back-pressure.
    typedef enum logic [2:0] {
        S_IDLE, S_UIR, S_CDR, S_SHIFT, S_UDR, S_RTI, S_RSP
    } state_t;

    // state_q is the observable FSM state for bound checkers.
    state_t              state_q, state_d;
    logic [HCW-1:0]      half_cnt;
    logic                phase;
    logic [BCW-1:0]      bit_cnt;
    logic [DR_WIDTH-1:0] data_q, cap_q, rsp_q;
    logic [IR_WIDTH-1:0] ir_q;
    logic                half_last, period_end, rise_edge, in_seq, accept;

    assign half_last  = (half_cnt == HCW'(TCK_DIV - 1));
    assign period_end = phase && half_last;
    assign rise_edge  = !phase && half_last;
    assign in_seq     = (state_q == S_UIR) || (state_q == S_CDR) || (state_q == S_SHIFT) ||
                        (state_q == S_UDR) || (state_q == S_RTI);
    assign accept     = cmd_valid && cmd_ready;
    assign rsp_data   = rsp_q;
    assign ir_in      = ir_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_valid)  state_d = S_UIR;
            S_UIR:   if (period_end) state_d = S_CDR;
            S_CDR:   if (period_end) state_d = S_SHIFT;
            S_SHIFT: if (period_end && bit_cnt == BCW'(DR_WIDTH - 1)) state_d = S_UDR;
            S_UDR:   if (period_end) state_d = S_RTI;
            S_RTI:   if (period_end) state_d = S_RSP;
            S_RSP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready      = (state_q == S_IDLE);
        rsp_valid      = (state_q == S_RSP);
        tck            = in_seq && phase;
        tdi            = (state_q == S_SHIFT) && data_q[0];
        vs_uir         = (state_q == S_UIR);
        vs_cdr         = (state_q == S_CDR);
        vs_sdr         = (state_q == S_SHIFT);
        vs_udr         = (state_q == S_UDR);
        jtag_state_rti = (state_q == S_RTI);
    end

    // Counters restart on every state entry so each state begins on a tck-low half.
    always_ff @(posedge clk) begin
        if (reset || (state_d != state_q) || !in_seq) begin
            half_cnt <= '0;
            phase    <= 1'b0;
            bit_cnt  <= '0;
        end else if (half_last) begin
            half_cnt <= '0;
            phase    <= !phase;
            if (phase && state_q == S_SHIFT) bit_cnt <= bit_cnt + BCW'(1);
        end else begin
            half_cnt <= half_cnt + HCW'(1);
        end
    end

    // tdo is taken on the edge that raises tck; tdi advances only at period ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            cap_q  <= '0;
            rsp_q  <= '0;
            ir_q   <= '0;
        end else begin
            if (accept) begin
                data_q <= cmd_data;
                ir_q   <= cmd_ir;
            end
            if (state_q == S_SHIFT && rise_edge)  cap_q  <= {tdo, cap_q[DR_WIDTH-1:1]};
            if (state_q == S_SHIFT && period_end) data_q <= data_q >> 1;
            if (state_q == S_RTI && period_end)   rsp_q  <= cap_q;
        end
    end
endmodule

// File: tb/tb_cpu_debug_jtag_master.sv
// Bench for cpu_debug_jtag_master: period-level reference model checked every cycle,
// plus directed scenarios with literal expectations (default build and TCK_DIV=1 build).
module tb_cpu_debug_jtag_master;
    localparam int DR = 38;
    localparam int IR = 2;
    localparam int T  = 2;
    localparam int NK = (DR + 4) * 2 * T;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Default build (TCK_DIV=2)
    logic          cmd_valid = 1'b0, cmd_ready, rsp_valid, tck, tdi, tdo;
    logic [IR-1:0] cmd_ir = '0, ir_in;
    logic [DR-1:0] cmd_data = '0, rsp_data;
    logic          vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti;
    logic          loop = 1'b1, tdo_fix = 1'b0;
    assign tdo = loop ? tdi : tdo_fix;

    cpu_debug_jtag_master #(.DR_WIDTH(DR), .IR_WIDTH(IR), .TCK_DIV(T)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .tck(tck), .tdi(tdi), .tdo(tdo), .ir_in(ir_in), .vs_uir(vs_uir), .vs_cdr(vs_cdr),
        .vs_sdr(vs_sdr), .vs_udr(vs_udr), .jtag_state_rti(jtag_state_rti)
    );

    // TCK_DIV=1 build, loopback
    logic          cmd_valid1 = 1'b0, cmd_ready1, rsp_valid1, tck1, tdi1, tdo1;
    logic [IR-1:0] cmd_ir1 = '0, ir_in1;
    logic [DR-1:0] cmd_data1 = '0, rsp_data1;
    logic          vs_uir1, vs_cdr1, vs_sdr1, vs_udr1, rti1;
    assign tdo1 = tdi1;

    cpu_debug_jtag_master #(.DR_WIDTH(DR), .IR_WIDTH(IR), .TCK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_ir(cmd_ir1), .cmd_data(cmd_data1), .rsp_valid(rsp_valid1), .rsp_data(rsp_data1),
        .tck(tck1), .tdi(tdi1), .tdo(tdo1), .ir_in(ir_in1), .vs_uir(vs_uir1), .vs_cdr(vs_cdr1),
        .vs_sdr(vs_sdr1), .vs_udr(vs_udr1), .jtag_state_rti(rti1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: position in the sequence is m_k cycles after acceptance.
    bit            check_en = 1'b0;
    bit            m_busy = 1'b0;
    int            m_k = 0;
    logic [DR-1:0] m_data = '0, m_cap = '0, m_rsp = '0;
    logic [IR-1:0] m_ir = '0;

    always @(negedge clk) begin : model_cmp
        int p, c;
        bit seq, e_tck, e_uir, e_cdr, e_sdr, e_udr, e_rti, e_tdi, e_rv;
        logic [DR-1:0] e_rd, tmp;
        if (check_en) begin
            p     = (m_k - 1) / (2 * T);
            c     = (m_k - 1) % (2 * T);
            seq   = m_busy && (m_k <= NK);
            e_rv  = m_busy && (m_k == NK + 1);
            e_rd  = e_rv ? m_cap : m_rsp;
            e_tck = seq && (c >= T);
            e_uir = seq && (p == 0);
            e_cdr = seq && (p == 1);
            e_sdr = seq && (p >= 2) && (p <= DR + 1);
            e_udr = seq && (p == DR + 2);
            e_rti = seq && (p == DR + 3);
            e_tdi = 1'b0;
            if (e_sdr) begin
                tmp   = m_data >> (p - 2);
                e_tdi = tmp[0];
            end
            chk("cmd_ready", cmd_ready, !m_busy);
            chk("rsp_valid", rsp_valid, e_rv);
            chk("rsp_data", rsp_data, e_rd);
            chk("tck", tck, e_tck);
            chk("tdi", tdi, e_tdi);
            chk("ir_in", ir_in, m_ir);
            chk("vs_uir", vs_uir, e_uir);
            chk("vs_cdr", vs_cdr, e_cdr);
            chk("vs_sdr", vs_sdr, e_sdr);
            chk("vs_udr", vs_udr, e_udr);
            chk("rti", jtag_state_rti, e_rti);

            if (reset) begin
                m_busy = 1'b0;
                m_k    = 0;
                m_ir   = '0;
                m_rsp  = '0;
            end else if (!m_busy) begin
                if (cmd_valid) begin
                    m_busy = 1'b1;
                    m_k    = 1;
                    m_data = cmd_data;
                    m_ir   = cmd_ir;
                    m_cap  = '0;
                end
            end else begin
                if (e_sdr && c == T - 1) m_cap = m_cap | (DR'(tdo) << (p - 2));
                if (m_k == NK + 1) begin
                    m_busy = 1'b0;
                    m_rsp  = m_cap;
                end else begin
                    m_k++;
                end
            end
        end
    end

    task automatic send(input logic [IR-1:0] ir, input logic [DR-1:0] d, input bit hold,
                        output int acc);
        @(posedge clk); #1;
        cmd_ir    = ir;
        cmd_data  = d;
        cmd_valid = 1'b1;
        acc       = cyc;
        @(posedge clk); #1;
        if (!hold) cmd_valid = 1'b0;
        cmd_data = ~d;
        cmd_ir   = ~ir;
    endtask

    task automatic wait_rsp(input int acc, output int lat, output logic [DR-1:0] d,
                            output int sdr_rise, output int tdi_ones, output int accepts);
        logic prev_tck;
        bit   got;
        prev_tck = 1'b0;
        got      = 1'b0;
        lat      = -1;
        d        = '0;
        sdr_rise = 0;
        tdi_ones = 0;
        accepts  = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (vs_sdr && tck && !prev_tck) sdr_rise++;
            if (vs_sdr && tdi) tdi_ones++;
            if (cmd_valid && cmd_ready) accepts++;
            prev_tck = tck;
            if (rsp_valid) begin
                got = 1'b1;
                lat = cyc - acc;
                d   = rsp_data;
            end
        end
        if (!got) chk("rsp_timeout", 64'd0, 64'd1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int acc, acc2, lat, sr, t1, ac, cnt, toggles;
        logic [DR-1:0] d;
        logic prev;

        // Reset held 3 cycles
        @(posedge clk); #1;
        check_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", cmd_ready, 1);
        chk("reset_tck", tck, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_ir_in", ir_in, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (tck) cnt++;
        end
        chk("idle_tck_high_cycles", cnt, 0);

        // Loopback, default build
        loop = 1'b1;
        send(2'b01, 38'h2A_5A5A_C3C3, 1'b0, acc);
        wait_rsp(acc, lat, d, sr, t1, ac);
        chk("loop_latency", lat, 169);
        chk("loop_rsp_data", d, 38'h2A_5A5A_C3C3);
        chk("loop_sdr_tck_rises", sr, 38);
        chk("loop_ir_in", ir_in, 2'b01);

        // Reset mid-idle
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_reset_ir_in", ir_in, 0);
        chk("idle_reset_rsp_data", rsp_data, 0);
        chk("idle_reset_ready", cmd_ready, 1);
        @(posedge clk); #1;
        reset = 1'b0;

        // tdo held high, zero data
        loop    = 1'b0;
        tdo_fix = 1'b1;
        send(2'b11, 38'h0, 1'b0, acc);
        wait_rsp(acc, lat, d, sr, t1, ac);
        chk("fixed_latency", lat, 169);
        chk("fixed_rsp_data", d, 38'h3F_FFFF_FFFF);
        chk("fixed_tdi_ones", t1, 0);
        chk("fixed_ir_in", ir_in, 2'b11);

        // Second loopback pattern
        loop = 1'b1;
        send(2'b10, 38'h15_A5A5_3C3C, 1'b0, acc);
        wait_rsp(acc, lat, d, sr, t1, ac);
        chk("loop2_rsp_data", d, 38'h15_A5A5_3C3C);

        // cmd_valid held high across the whole sequence
        send(2'b01, 38'h01_2345_6789, 1'b1, acc);
        cmd_data = 38'h3E_DCBA_9876;
        wait_rsp(acc, lat, d, sr, t1, ac);
        chk("busy_latency", lat, 169);
        chk("busy_rsp_data", d, 38'h01_2345_6789);
        chk("busy_accepts_during_seq", ac, 0);
        @(posedge clk); #1;
        acc2 = cyc;
        @(negedge clk);
        chk("busy_reaccept_ready", cmd_ready, 1);
        chk("busy_reaccept_spacing", acc2 - acc, 170);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_rsp(acc2, lat, d, sr, t1, ac);
        chk("busy2_latency", lat, 169);
        chk("busy2_rsp_data", d, 38'h3E_DCBA_9876);

        // Reset while shifting bit 17 (period 19 of the sequence)
        send(2'b10, 38'h0F_0F0F_0F0F, 1'b0, acc);
        repeat (76) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("pre_reset_sdr", vs_sdr, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_tck", tck, 0);
        chk("abort_sdr", vs_sdr, 0);
        chk("abort_ir_in", ir_in, 0);
        chk("abort_ready", cmd_ready, 1);
        cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        chk("abort_no_rsp", cnt, 0);
        send(2'b01, 38'h33_CCCC_5555, 1'b0, acc);
        wait_rsp(acc, lat, d, sr, t1, ac);
        chk("fresh_latency", lat, 169);
        chk("fresh_rsp_data", d, 38'h33_CCCC_5555);

        // TCK_DIV=1 build
        @(posedge clk); #1;
        cmd_valid1 = 1'b1;
        cmd_data1  = 38'h1;
        cmd_ir1    = 2'b01;
        acc        = cyc;
        @(posedge clk); #1;
        cmd_valid1 = 1'b0;
        cmd_data1  = '0;
        @(negedge clk);
        prev    = tck1;
        toggles = 0;
        lat     = -1;
        d       = '0;
        for (int i = 0; i < 200 && lat < 0; i++) begin
            @(negedge clk);
            if (tck1 != prev) toggles++;
            prev = tck1;
            if (rsp_valid1) begin
                lat = cyc - acc;
                d   = rsp_data1;
            end
        end
        chk("div1_latency", lat, 85);
        chk("div1_rsp_data", d, 38'h1);
        chk("div1_tck_toggles", toggles, 84);
        chk("div1_ir_in", ir_in1, 2'b01);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
